reg_writeback_ctrl: RTL
=======================

// Module: reg_writeback_ctrl
// PURPOSE
//  Writer side of the 16x16 register file. Merges single-cycle ALU results and multi-cycle load results
//  into the file's single write port (write_en/add/data). Tracks a scoreboard of in-flight destination
//  registers so the decode stage can stall on read-after-write hazards.
//  Sits between the execute/memory stages and the register file write port.
// PARAMETERS
//  DATA_W      16  register/data width
//  ADDR_W      4   register address width; NREG = 2**ADDR_W = 16
//  FIFO_DEPTH  4   load-result buffer entries (power of two, >=2)
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high
//  i_flush       in   1       pipeline flush
//  i_issue_en    in   1       instruction with destination issued
//  i_issue_add   in   ADDR_W  destination register of issued instruction
//  i_alu_valid   in   1       ALU result valid (no backpressure; always accepted)
//  i_alu_add     in   ADDR_W  ALU destination
//  i_alu_data    in   DATA_W  ALU result
//  i_ld_valid    in   1       load result valid
//  o_ld_ready    out  1       load result accepted when valid&ready
//  i_ld_add      in   ADDR_W  load destination
//  i_ld_data     in   DATA_W  load data
//  i_read_add1   in   ADDR_W  decode source operand 1
//  i_read_add2   in   ADDR_W  decode source operand 2
//  o_hazard      out  1       either source is busy in scoreboard
//  o_busy_mask   out  NREG    scoreboard, bit r = register r pending write
//  o_write_en    out  1       register file write enable (registered)
//  o_write_add   out  ADDR_W  register file write address (registered)
//  o_write_data  out  DATA_W  register file write data (registered)
// BEHAVIOUR
//  - Reset: o_write_en=0, o_write_add=0, o_write_data=0, o_busy_mask=0, FIFO empty, o_ld_ready=1.
//  - Load FIFO: push on i_ld_valid&o_ld_ready. o_ld_ready = !full (combinational from count only;
//    no push-through on simultaneous pop at full). Count 0..FIFO_DEPTH; pointers wrap mod FIFO_DEPTH.
//  - Write arbiter per cycle: ALU valid -> write ALU; else FIFO non-empty -> pop head, write it;
//    else o_write_en=0 (add/data hold last value). ALU strictly wins; FIFO drains in ALU idle cycles.
//  - Latency: ALU result cycle N -> o_write_en at N+1. Load accepted cycle N -> earliest write N+2.
//  - Writes leave in FIFO order; two loads never reorder.
//  - Scoreboard: issue sets bit; a performed write (o_write_en rising-edge update) clears bit of
//    o_write_add. Same-cycle set and clear of same register: set wins. Set of already-busy bit: stays 1.
//  - o_hazard = busy[i_read_add1] | busy[i_read_add2], combinational from registered mask.
//  - i_flush: next cycle FIFO empty, o_busy_mask=0, o_write_en=0; inputs in flush cycle ignored.
//  - reset has priority over i_flush; reset mid-drain discards all buffered loads.
// CONFIGURATION
//  WB_FORWARD_EN defined: adds o_fwd1_valid/o_fwd1_data, o_fwd2_valid/o_fwd2_data (combinational);
//    fwdK_valid = o_write_en & (o_write_add == i_read_addK), data = o_write_data; o_hazard then
//    excludes a source being forwarded this cycle.
//  Not defined: no forwarding ports; o_hazard as above.
// STRUCTURE
//  cpu_pkg: DATA_W/ADDR_W/NREG constants, typedef wb_req_t {add, data}.
//  Sub-module wb_fifo (FIFO_DEPTH x wb_req_t, count-based full/empty); arbiter + scoreboard in top.
// TESTING
//  1. ALU valid add=3 data=0x1234 at N -> write_en=1, add=3, data=0x1234 at N+1 only.
//  2. ALU and load (add=5,0xBEEF) same cycle -> ALU written N+1, load written N+2.
//  3. ALU valid every cycle, 5 loads offered -> 4 accepted, ld_ready=0 at full; drain in order after ALU idles.
//  4. Issue r7 -> busy_mask[7]=1, read_add1=7 gives hazard=1; after write to r7 bit clears; issue+write r7 same cycle -> stays 1.
//  5. Flush with 3 buffered loads and busy mask 0x00F0 -> next cycle mask=0, no further writes, ld_ready=1.
//  6. WB_FORWARD_EN: write r2=0x00AA while read_add2=2 -> fwd2_valid=1, data=0x00AA, hazard=0.

Source files
------------

// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared constants and the write-request bundle for the register writeback path.
// Provides DATA_W, ADDR_W, NREG and wb_req_t {add, data}.
package reg_writeback_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Load-result buffer: DEPTH entries of wb_req_t, count-based full/empty.
// Ports: clk, reset, flush, push/push_add/push_data, pop, head_add/head_data, full, empty.
module wb_fifo
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_add,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_add,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign head_add  = mem[rd_ptr].add;
    assign head_data = mem[rd_ptr].data;

    // Pointers are PW bits wide, so they wrap mod DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{add: push_add, data: push_data};
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register file writer: merges ALU and buffered load results onto one write port
// and keeps a busy scoreboard for RAW hazard detection at decode.
// Ports: clk, reset, i_flush, issue (i_issue_*), ALU (i_alu_*), load (i_ld_*, o_ld_ready),
// decode sources (i_read_add1/2), o_hazard, o_busy_mask, write port (o_write_*).
// Define WB_FORWARD_EN to add o_fwd1/2_valid/data bypass outputs.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_issue_en,
    input  logic [ADDR_W-1:0] i_issue_add,
    input  logic              i_alu_valid,
    input  logic [ADDR_W-1:0] i_alu_add,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [ADDR_W-1:0] i_ld_add,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic [ADDR_W-1:0] i_read_add1,
    input  logic [ADDR_W-1:0] i_read_add2,
    output logic              o_hazard,
    output logic [NREG-1:0]   o_busy_mask,
`ifdef WB_FORWARD_EN
    output logic              o_fwd1_valid,
    output logic [DATA_W-1:0] o_fwd1_data,
    output logic              o_fwd2_valid,
    output logic [DATA_W-1:0] o_fwd2_data,
`endif
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_write_add,
    output logic [DATA_W-1:0] o_write_data
);

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ADDR_W-1:0] head_add;
    logic [DATA_W-1:0] head_data;
    logic [NREG-1:0]   busy_nxt;
    logic              busy1;
    logic              busy2;

    assign o_ld_ready = !fifo_full;
    assign fifo_push  = i_ld_valid && !fifo_full && !i_flush;
    // FIFO only drains in cycles the ALU leaves the port idle.
    assign fifo_pop   = !i_alu_valid && !fifo_empty && !i_flush;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (i_flush),
        .push     (fifo_push),
        .push_add (i_ld_add),
        .push_data(i_ld_data),
        .pop      (fifo_pop),
        .head_add (head_add),
        .head_data(head_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The write on the port this cycle retires its register; a new issue
    // to the same register in the same cycle keeps it busy.
    always_comb begin
        busy_nxt = o_busy_mask;
        if (o_write_en) begin
            busy_nxt[o_write_add] = 1'b0;
        end
        if (i_issue_en) begin
            busy_nxt[i_issue_add] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_write_en   <= 1'b0;
            o_write_add  <= '0;
            o_write_data <= '0;
            o_busy_mask  <= '0;
        end else if (i_flush) begin
            o_write_en   <= 1'b0;
            o_busy_mask  <= '0;
        end else begin
            o_busy_mask <= busy_nxt;
            if (i_alu_valid) begin
                o_write_en   <= 1'b1;
                o_write_add  <= i_alu_add;
                o_write_data <= i_alu_data;
            end else if (!fifo_empty) begin
                o_write_en   <= 1'b1;
                o_write_add  <= head_add;
                o_write_data <= head_data;
            end else begin
                o_write_en   <= 1'b0;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign o_fwd1_valid = o_write_en && (o_write_add == i_read_add1);
    assign o_fwd2_valid = o_write_en && (o_write_add == i_read_add2);
    assign o_fwd1_data  = o_write_data;
    assign o_fwd2_data  = o_write_data;
    assign busy1 = o_busy_mask[i_read_add1] && !o_fwd1_valid;
    assign busy2 = o_busy_mask[i_read_add2] && !o_fwd2_valid;
`else
    assign busy1 = o_busy_mask[i_read_add1];
    assign busy2 = o_busy_mask[i_read_add2];
`endif

    assign o_hazard = busy1 || busy2;

endmodule
